// File: rtl/trellis_ff_bank_model.sv
// Behavioural model of a bank of ECP5 slice registers decoded from TRELLIS_FF
// attributes: FF or transparent-latch mode, sync/async LSR, GSR, mux polarities.
module trellis_ff_bank_model #(
  parameter int    WIDTH   = 1,
  parameter string GSR     = "ENABLED",
  parameter string CEMUX   = "CE",
  parameter string CLKMUX  = "CLK",
  parameter string LSRMUX  = "LSR",
  parameter string REGSET  = "RESET",
  parameter string SRMODE  = "ASYNC",
  parameter string REGMODE = "FF"
) (
  input  logic             CLK,
  input  logic             GSRN,
  input  logic             CE,
  input  logic             LSR,
  input  logic [WIDTH-1:0] DI,
  output logic [WIDTH-1:0] Q
);

  localparam bit GSR_OK    = (GSR == "ENABLED") || (GSR == "DISABLED");
  localparam bit CEMUX_OK  = (CEMUX == "CE") || (CEMUX == "INV") ||
                             (CEMUX == "1") || (CEMUX == "0");
  localparam bit CLKMUX_OK = (CLKMUX == "CLK") || (CLKMUX == "INV");
  localparam bit LSRMUX_OK = (LSRMUX == "LSR") || (LSRMUX == "INV") || (LSRMUX == "0");
  localparam bit REGSET_OK = (REGSET == "RESET") || (REGSET == "SET");
  localparam bit SRMODE_OK = (SRMODE == "ASYNC") || (SRMODE == "LSR_OVER_CE");
  localparam bit REGMODE_OK = (REGMODE == "FF") || (REGMODE == "LATCH");

  localparam bit GSR_EN   = (GSR == "ENABLED");
  localparam bit CE_TIE1  = (CEMUX == "1");
  localparam bit CE_TIE0  = (CEMUX == "0");
  localparam bit CE_INV   = (CEMUX == "INV");
  localparam bit CLK_INV  = (CLKMUX == "INV");
  localparam bit LSR_OFF  = (LSRMUX == "0");
  localparam bit LSR_INV  = (LSRMUX == "INV");
  localparam bit IS_LATCH = (REGMODE == "LATCH");
  // Latch mode treats LSR as level-sensitive whatever SRMODE says.
  localparam bit SYNC_LSR = (SRMODE == "LSR_OVER_CE") && !IS_LATCH;
  localparam logic [WIDTH-1:0] SV = {WIDTH{REGSET == "SET"}};

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "trellis_ff_bank_model: WIDTH must be at least 1");
  end
  if (!(GSR_OK && CEMUX_OK && CLKMUX_OK && LSRMUX_OK &&
        REGSET_OK && SRMODE_OK && REGMODE_OK)) begin : g_bad_attr
    $fatal(1, "trellis_ff_bank_model: illegal attribute string");
  end

  logic             clk_e;
  logic             ce_e;
  logic             lsr_e;
  logic             lsr_sync;
  logic             async_n;
  logic [WIDTH-1:0] q_r;
  // NOTE: a 2-state bit starts at 0 in every simulator, so Q reads SV from
  // time 0 without an initial block or a declaration initializer.
  bit               q_valid;

  assign clk_e    = CLK ^ CLK_INV;
  assign ce_e     = CE_TIE1 ? 1'b1 : (CE_TIE0 ? 1'b0 : (CE ^ CE_INV));
  assign lsr_e    = LSR_OFF ? 1'b0 : (LSR ^ LSR_INV);
  assign lsr_sync = SYNC_LSR & lsr_e;
  assign async_n  = ~((GSR_EN & ~GSRN) | (~SYNC_LSR & lsr_e));
  assign Q        = q_valid ? q_r : SV;

  if (IS_LATCH) begin : g_latch
    // NOTE: the storage here is an intended level-sensitive latch, so it is
    // written as always_latch rather than an always_comb with a missing else.
    always_latch begin
      if (!async_n) begin
        q_r     <= SV;
        q_valid <= 1'b1;
      end else if (clk_e && ce_e) begin
        q_r     <= DI;
        q_valid <= 1'b1;
      end
    end
  end else begin : g_ff
    // Set while any async reset is active and kept set until clk_e is low, so
    // a reset released on an active edge does not let that edge capture DI.
    logic release_hold;

    always_latch begin
      if (!async_n)    release_hold <= 1'b1;
      else if (!clk_e) release_hold <= 1'b0;
    end

    always_ff @(posedge clk_e or negedge async_n) begin
      if (!async_n) begin
        q_r     <= SV;
        q_valid <= 1'b1;
      end else if (!release_hold) begin
        // NOTE: ?: rather than if/else so an X on CE or LSR merges both
        // candidates bitwise, turning only the bits that could differ into X.
        q_r     <= lsr_sync ? SV : (ce_e ? DI : Q);
        q_valid <= 1'b1;
      end
    end
  end

endmodule
